ipif_reg_master: RTL

- Initiator end of the IPIF register bus: converts single-word register commands from local logic into IPIF transactions.
- Typical command sources are a config sequencer or a host-command FIFO.
- Drives Bus2IP_* toward an IPIF register-file slave, waits for RdAck/WrAck/Error, and returns a response word.
- One outstanding transaction at a time; used for in-fabric register initialisation and for bridging.

---
 rtl/ipif_master_pkg.sv | 28 ++
 rtl/ipif_reg_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ipif_master_pkg.sv
// Shared types and helpers for the IPIF register-bus initiator.
// Holds the transaction state encoding, the response status codes
// and a constant-foldable clog2 used to size the wait-state counter.
package ipif_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Response status packed as {timeout, error}; a timeout always implies error
   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_ERROR   = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT = 2'b11;

   // Number of bits needed to hold values 0 .. value-1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ipif_reg_master.sv
// IPIF register-bus initiator: turns single-word read/write commands from
// local logic into one Bus2IP_* transaction, waits for the matching ack or
// IP2Bus_Error and hands back a response word. One transaction in flight.
// Optional wait-state abort is compiled in with IPIF_MASTER_TIMEOUT_EN.
module ipif_reg_master
   import ipif_master_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 64
) (
   input  logic                              Bus2IP_Clk,
   input  logic                              Bus2IP_Reset,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_rnw,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     cmd_data,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   cmd_be,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_data,
   output logic                              rsp_error,
   output logic                              rsp_timeout,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
   output logic                              Bus2IP_CS,
   output logic                              Bus2IP_RNW,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
   input  logic                              IP2Bus_RdAck,
   input  logic                              IP2Bus_WrAck,
   input  logic                              IP2Bus_Error
);

   if (((C_S_AXI_DATA_WIDTH % 8) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
      $error("ipif_reg_master: data width must be a multiple of 8 and TIMEOUT_CYCLES >= 2");
   end

   state_t state, next_state;

   logic                            nxt_cmd_ready;
   logic                            nxt_rsp_valid;
   logic [C_S_AXI_DATA_WIDTH-1:0]   nxt_rsp_data;
   logic [1:0]                      rsp_status, nxt_rsp_status;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   nxt_addr;
   logic                            nxt_cs;
   logic                            nxt_rnw;
   logic [C_S_AXI_DATA_WIDTH-1:0]   nxt_wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] nxt_be;

   logic wait_done;
   logic wait_expired;

   // Only the ack that matches the transaction direction ends it; an error always does
   assign wait_done = IP2Bus_Error || (Bus2IP_RNW ? IP2Bus_RdAck : IP2Bus_WrAck);

`ifdef IPIF_MASTER_TIMEOUT_EN
   localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt, nxt_wait_cnt;
   // The count reaches TIMEOUT_CYCLES on the edge that leaves WAIT
   assign wait_expired = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign wait_expired = 1'b0;
`endif

   assign rsp_error   = rsp_status[0];
   assign rsp_timeout = rsp_status[1];

   // State and every output / datapath register, cleared asynchronously so reset aborts at once
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         state       <= ST_IDLE;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_status  <= RSP_OK;
         Bus2IP_Addr <= '0;
         Bus2IP_CS   <= 1'b0;
         Bus2IP_RNW  <= 1'b0;
         Bus2IP_Data <= '0;
         Bus2IP_BE   <= '0;
`ifdef IPIF_MASTER_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         state       <= next_state;
         cmd_ready   <= nxt_cmd_ready;
         rsp_valid   <= nxt_rsp_valid;
         rsp_data    <= nxt_rsp_data;
         rsp_status  <= nxt_rsp_status;
         Bus2IP_Addr <= nxt_addr;
         Bus2IP_CS   <= nxt_cs;
         Bus2IP_RNW  <= nxt_rnw;
         Bus2IP_Data <= nxt_wdata;
         Bus2IP_BE   <= nxt_be;
`ifdef IPIF_MASTER_TIMEOUT_EN
         wait_cnt    <= nxt_wait_cnt;
`endif
      end
   end

   // Transaction sequencing: REQ always lasts exactly one cycle so CS is a single pulse
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (cmd_valid && cmd_ready) next_state = ST_REQ;
         ST_REQ:  next_state = ST_WAIT;
         ST_WAIT: if (wait_done || wait_expired) next_state = ST_RESP;
         ST_RESP: if (rsp_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; anything not touched holds, so stray acks do nothing
   always_comb begin
      nxt_cmd_ready  = cmd_ready;
      nxt_rsp_valid  = rsp_valid;
      nxt_rsp_data   = rsp_data;
      nxt_rsp_status = rsp_status;
      nxt_addr       = Bus2IP_Addr;
      nxt_cs         = Bus2IP_CS;
      nxt_rnw        = Bus2IP_RNW;
      nxt_wdata      = Bus2IP_Data;
      nxt_be         = Bus2IP_BE;
`ifdef IPIF_MASTER_TIMEOUT_EN
      nxt_wait_cnt   = wait_cnt;
`endif
      case (state)
         ST_IDLE: begin
            nxt_cmd_ready = 1'b1;
            if (cmd_valid && cmd_ready) begin
               nxt_cmd_ready = 1'b0;
               nxt_addr      = cmd_addr;
               nxt_rnw       = cmd_rnw;
               nxt_wdata     = cmd_rnw ? '0 : cmd_data;
               nxt_be        = cmd_be;
               nxt_cs        = 1'b1;
            end
         end
         ST_REQ: begin
            nxt_cs = 1'b0;
`ifdef IPIF_MASTER_TIMEOUT_EN
            nxt_wait_cnt = '0;
`endif
         end
         ST_WAIT: begin
`ifdef IPIF_MASTER_TIMEOUT_EN
            if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) nxt_wait_cnt = wait_cnt + 1'b1;
`endif
            if (wait_done) begin
               nxt_rsp_valid  = 1'b1;
               nxt_rsp_data   = Bus2IP_RNW ? IP2Bus_Data : '0;
               nxt_rsp_status = IP2Bus_Error ? RSP_ERROR : RSP_OK;
            end else if (wait_expired) begin
               nxt_rsp_valid  = 1'b1;
               nxt_rsp_data   = '0;
               nxt_rsp_status = RSP_TIMEOUT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               nxt_rsp_valid  = 1'b0;
               nxt_rsp_status = RSP_OK;
               nxt_cmd_ready  = 1'b1;
            end
         end
         default: begin
            nxt_cs = 1'b0;
         end
      endcase
   end

endmodule
